// File: rtl/softmax_argmax_pkg.sv
// Shared definitions for the softmax argmax block: word widths, FSM state
// encoding and FP32 field helpers used by the comparator and the top level.
package softmax_argmax_pkg;

    localparam int DATALENGTH = 32;
    localparam int INPUTMAX   = 5;

    localparam int          SIGN_BIT     = 31;
    localparam logic [7:0]  EXP_ALL_ONES = 8'hff;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    // A NaN has an all-ones exponent and a non-zero mantissa.
    function automatic logic is_nan(input logic [DATALENGTH-1:0] x);
        return (x[30:23] == EXP_ALL_ONES) && (x[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/softmax_argmax_fp32_gt.sv
// Combinational FP32 "a strictly greater than b" under IEEE total order,
// with NaN handling tailored for a running maximum: a NaN candidate never
// wins, and any non-NaN candidate beats a NaN incumbent.
module softmax_argmax_fp32_gt
    import softmax_argmax_pkg::*;
(
    input  logic [DATALENGTH-1:0] a,
    input  logic [DATALENGTH-1:0] b,
    output logic                  gt
);

    logic [DATALENGTH-1:0] key_a;
    logic [DATALENGTH-1:0] key_b;
    logic                  nan_a;
    logic                  nan_b;

    // Map sign-magnitude words onto unsigned keys whose order matches the
    // float order; both zeros collapse onto the same key so they tie.
    function automatic logic [DATALENGTH-1:0] order_key(input logic [DATALENGTH-1:0] x);
        logic [DATALENGTH-1:0] k;
        if (x[DATALENGTH-2:0] == '0) begin
            k = {1'b1, {(DATALENGTH-1){1'b0}}};
        end else if (x[SIGN_BIT]) begin
            k = ~x;
        end else begin
            k = x | {1'b1, {(DATALENGTH-1){1'b0}}};
        end
        return k;
    endfunction

    // Resolve NaN cases first, otherwise compare the ordered keys.
    always_comb begin
        key_a = order_key(a);
        key_b = order_key(b);
        nan_a = is_nan(a);
        nan_b = is_nan(b);
        gt    = 1'b0;
        if (nan_a) begin
            gt = 1'b0;
        end else if (nan_b) begin
            gt = 1'b1;
        end else begin
            gt = (key_a > key_b);
        end
    end

endmodule

// File: rtl/softmax_argmax.sv
// Argmax over a frame of FP32 softmax probabilities. Collects N beats,
// tracks the running maximum and pulses Done with the winning index/value.
module softmax_argmax
    import softmax_argmax_pkg::*;
(
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [INPUTMAX-1:0]   N,
    input  logic                  InValid,
    input  logic [DATALENGTH-1:0] Datain,
    output logic [INPUTMAX-1:0]   BestIndex,
    output logic [DATALENGTH-1:0] BestValue,
    output logic                  Done,
    output logic                  Busy,
    output logic                  Error
);

    state_t                state;
    state_t                next_state;
    logic [INPUTMAX-1:0]   n_reg;
    logic [INPUTMAX-1:0]   count;
    logic [INPUTMAX-1:0]   best_index;
    logic [DATALENGTH-1:0] best_value;
    logic                  best_valid;
    logic                  error_q;
    logic                  cand_gt;
    logic                  accept;
    logic                  last_beat;
    logic                  replace;

    softmax_argmax_fp32_gt u_gt (
        .a  (Datain),
        .b  (best_value),
        .gt (cand_gt)
    );

    assign accept    = (state == COLLECT) && InValid;
    assign last_beat = (count == (n_reg - INPUTMAX'(1)));
    assign replace   = !best_valid || cand_gt;

    // State register; a low Reset aborts any frame in flight.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: empty frames skip straight to DONE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (Start) begin
                    next_state = (N == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (accept && last_beat) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        Done = 1'b0;
        Busy = 1'b0;
        case (state)
            COLLECT: Busy = 1'b1;
            DONE:    Done = 1'b1;
            default: ;
        endcase
    end

    // Frame length latch, beat counter and running-best registers.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            n_reg      <= '0;
            count      <= '0;
            best_index <= '0;
            best_value <= '0;
            best_valid <= 1'b0;
            error_q    <= 1'b0;
        end else if (state == IDLE && Start) begin
            n_reg      <= N;
            count      <= '0;
            best_valid <= 1'b0;
            error_q    <= (N == '0);
            if (N == '0) begin
                best_index <= '0;
                best_value <= '0;
            end
        end else if (accept) begin
            count <= count + INPUTMAX'(1);
            if (replace) begin
                best_index <= count;
                best_value <= Datain;
                best_valid <= 1'b1;
            end
        end
    end

    assign BestIndex = best_index;
    assign BestValue = best_value;
    assign Error     = error_q;

endmodule
